// File: rtl/gb_pkg.sv
// gb_pkg: shared state encoding, kernel weights and arithmetic widths for gauss_blur_3x3
package gb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } gb_state_t;

    localparam int SUM_W      = 12;
    localparam int ROUND_BIAS = 8;
    localparam int SHIFT      = 4;

    // row-major 3x3 kernel [1 2 1; 2 4 2; 1 2 1], normalised by >> SHIFT
    localparam logic [2:0] KERNEL [9] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd4, 3'd2, 3'd1, 3'd2, 3'd1};

endpackage

// File: rtl/gb_line_buffer.sv
// gb_line_buffer: W-deep shift register delaying the accepted pixel stream by one frame row
module gb_line_buffer
    import gb_pkg::*;
#(
    parameter int W  = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] tap
);

    logic [DW-1:0] sr [W];

    // contents are don't-care after reset: taps are only consumed once a full row has been written
    always_ff @(posedge clk) begin
        if (en) begin
            sr[0] <= din;
            for (int i = 1; i < W; i++) sr[i] <= sr[i-1];
        end
    end

    assign tap = sr[W-1];

endmodule

// File: rtl/gauss_blur_3x3.sv
// gauss_blur_3x3: 3x3 Gaussian blur of a raster pixel stream; define GB_ROUND_EN for rounded instead of truncated output
module gauss_blur_3x3
    import gb_pkg::*;
#(
    parameter int W  = 5,
    parameter int H  = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          GB_enable,
    input  logic          in_valid,
    input  logic [DW-1:0] Din,
    output logic [DW-1:0] Dout,
    output logic          out_valid,
    output logic          GB_done
);

    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    gb_state_t      state, state_next;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [DW-1:0]  win [3][3];
    logic [DW-1:0]  nw  [3][3];
    logic [DW-1:0]  col_new [3];
    logic [DW-1:0]  tap1, tap2;
    logic [SUM_W-1:0] kernel_sum, res;
    logic [DW-1:0]  dout_next;
    logic           accept, abort, last, emit;

    assign accept  = (state == RUN) && GB_enable && in_valid;
    assign abort   = ((state == RUN) || (state == DRAIN)) && !GB_enable;
    assign last    = (row == RW'(H-1)) && (col == CW'(W-1));
    assign emit    = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign GB_done = (state == DONE);

    gb_line_buffer #(.W(W), .DW(DW)) u_lb1 (.clk(clk), .en(accept), .din(Din),  .tap(tap1));
    gb_line_buffer #(.W(W), .DW(DW)) u_lb2 (.clk(clk), .en(accept), .din(tap1), .tap(tap2));

    // incoming column, oldest row on top
    assign col_new[0] = tap2;
    assign col_new[1] = tap1;
    assign col_new[2] = Din;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // next-state: frame sequencing with abort whenever enable drops mid-frame
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = GB_enable ? RUN : IDLE;
            RUN:     state_next = !GB_enable ? IDLE : (accept && last) ? DRAIN : RUN;
            DRAIN:   state_next = !GB_enable ? IDLE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // window after shifting in the current column, then the weighted sum over it
    always_comb begin
        kernel_sum = '0;
        for (int i = 0; i < 3; i++) begin
            nw[i][0] = win[i][1];
            nw[i][1] = win[i][2];
            nw[i][2] = col_new[i];
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                kernel_sum = kernel_sum + SUM_W'(KERNEL[i*3+j]) * SUM_W'(nw[i][j]);
`ifdef GB_ROUND_EN
        res = kernel_sum + SUM_W'(ROUND_BIAS);
`else
        res = kernel_sum;
`endif
        dout_next = DW'(res >> SHIFT);
    end

    // raster position of the next accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (abort || state == DONE) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            col <= (col == CW'(W-1)) ? '0 : col + 1'b1;
            if (col == CW'(W-1)) row <= last ? '0 : row + 1'b1;
        end
    end

    // 3x3 window keeps shifting across row wraps; emit gating hides the mixed windows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      win <= '{default: '0};
        else if (abort)  win <= '{default: '0};
        else if (accept) win <= nw;
    end

    // one-cycle result register; Dout holds between results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Dout      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= emit;
            if (emit) Dout <= dout_next;
        end
    end

endmodule

// File: tb/tb_gauss_blur_3x3.sv
// tb_gauss_blur_3x3: randomized stream bench with a frame-level blur model and per-cycle output checks
module tb_gauss_blur_3x3;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int DW = 8;
    localparam int N  = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          GB_enable = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] Din = '0;
    logic [DW-1:0] Dout;
    logic          out_valid;
    logic          GB_done;

    gauss_blur_3x3 #(.W(W), .H(H), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .GB_enable(GB_enable), .in_valid(in_valid),
        .Din(Din), .Dout(Dout), .out_valid(out_valid), .GB_done(GB_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit exp_v [N];
    int exp_d [N];
    bit exp_done [N];
    int m_dout = 0;
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int got_q [$];
    int pix [H][W];
    int d0;
    int cst [9];
    int ramp_exp [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
`ifdef GB_ROUND_EN
    int imp_exp [9] = '{16, 32, 16, 32, 64, 32, 16, 32, 16};
`else
    int imp_exp [9] = '{15, 31, 15, 31, 63, 31, 15, 31, 15};
`endif

    function automatic void chk(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    function automatic int blur(int r, int c);
        int s = 0;
        for (int i = -1; i <= 1; i++)
            for (int j = -1; j <= 1; j++)
                s += (i == 0 ? 2 : 1) * (j == 0 ? 2 : 1) * pix[r+i][c+j];
`ifdef GB_ROUND_EN
        return (s + 8) / 16;
`else
        return s / 16;
`endif
    endfunction

    // per-cycle comparison against the model's expected outputs
    always @(negedge clk) begin
        if (cyc < N) begin
            if (!rst_n) m_dout = 0;
            else if (exp_v[cyc]) m_dout = exp_d[cyc];
            chk("out_valid", int'(out_valid), int'(exp_v[cyc]));
            chk("Dout", int'(Dout), m_dout);
            chk("GB_done", int'(GB_done), int'(exp_done[cyc]));
        end
        if (out_valid) got_q.push_back(int'(Dout));
        if (GB_done) done_cnt++;
    end

    task automatic step(input bit en, input bit v, input int d);
        GB_enable = en;
        in_valid  = v;
        Din       = DW'(d);
        @(posedge clk);
        #1;
    endtask

    // kind: 0 constant, 1 impulse, 2 ramp, 3 random; first cycle is the IDLE->RUN cycle with junk input
    task automatic send_frame(input int kind, input int val, input int gap, input int npix);
        int n = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                pix[r][c] = kind == 0 ? val :
                            kind == 1 ? ((r == 2 && c == 2) ? 255 : 0) :
                            kind == 2 ? r * W + c : int'($urandom_range(255));
        step(1, 1, $urandom_range(255));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (n < npix) begin
                    while ($urandom_range(99) < gap) step(1, 0, $urandom_range(255));
                    if (r >= 2 && c >= 2) begin
                        exp_v[cyc+1] = 1'b1;
                        exp_d[cyc+1] = blur(r - 1, c - 1);
                    end
                    if (r == H - 1 && c == W - 1) exp_done[cyc+2] = 1'b1;
                    step(1, 1, pix[r][c]);
                    n++;
                end
        if (npix >= H * W) begin
            step(1, 1, $urandom_range(255));
            step(1, 1, $urandom_range(255));
        end
    endtask

    task automatic check_list(input string name, input int want [9]);
        chk({name, "_count"}, got_q.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < got_q.size()) chk(name, got_q[i], want[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #2 rst_n = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        rst_n = 1'b1;
        step(0, 1, 33);

        for (int i = 0; i < 9; i++) cst[i] = 100;
        got_q.delete(); d0 = done_cnt;
        send_frame(0, 100, 0, 25);
        check_list("const100", cst);
        chk("const100_done", done_cnt - d0, 1);

        got_q.delete(); d0 = done_cnt;
        send_frame(1, 0, 0, 25);
        check_list("impulse", imp_exp);
        chk("impulse_done", done_cnt - d0, 1);

        got_q.delete(); d0 = done_cnt;
        send_frame(0, 100, 30, 25);
        check_list("const100_gaps", cst);
        chk("gaps_done", done_cnt - d0, 1);

        got_q.delete(); d0 = done_cnt;
        send_frame(3, 0, 0, 12);
        step(0, 1, $urandom_range(255));
        step(0, 0, 0);
        step(0, 0, 0);
        chk("abort_outputs", got_q.size(), 0);
        chk("abort_done", done_cnt - d0, 0);

        got_q.delete(); d0 = done_cnt;
        send_frame(2, 0, 0, 25);
        check_list("ramp", ramp_exp);
        chk("ramp_done", done_cnt - d0, 1);

        send_frame(0, 77, 0, 14);
        rst_n = 1'b0;
        for (int i = cyc; i < N; i++) begin
            exp_v[i] = 1'b0;
            exp_done[i] = 1'b0;
        end
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_Dout", int'(Dout), 0);
        chk("rst_GB_done", int'(GB_done), 0);
        step(1, 0, 0);
        step(1, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) cst[i] = 200;
        got_q.delete(); d0 = done_cnt;
        send_frame(0, 200, 0, 25);
        check_list("after_reset", cst);
        chk("after_reset_done", done_cnt - d0, 1);

        d0 = done_cnt;
        send_frame(3, 0, 0, 25);
        got_q.delete();
        for (int i = 0; i < 9; i++) cst[i] = 50;
        send_frame(0, 50, 0, 25);
        check_list("b2b_second", cst);
        chk("b2b_done", done_cnt - d0, 2);

        repeat (4) send_frame(3, 0, 30, 25);
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
